// File: rtl/reg_file_param.sv
// reg_file_param: parameterised register file, one write port and NRD
// registered read ports sharing a common read enable.
//
// Ports:
//   clk      rising-edge clock for all state
//   rst      asynchronous active-high reset (clears storage, flags, outputs)
//   wr_en    write request; wr_addr / wr_data give target entry and value
//   rd_en    read enable common to all read ports
//   rd_addr  NRD packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  NRD packed registered read values, port i at [i*DATA_W +: DATA_W]
//   rd_init  per port: the returned entry has been written since reset
module reg_file_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    output logic [NRD-1:0]           rd_init
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DATA_W-1:0]     mem_d [DEPTH];
    logic [DEPTH-1:0]      flag_q, flag_d;
    logic [NRD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NRD-1:0]        rd_init_q, rd_init_d;
    logic                  wr_accept_c;
    logic [ADDR_W-1:0]     ra;

    // Writes to entry 0 are dropped when it is hardwired to zero.
    assign wr_accept_c = wr_en && !((ZERO_REG != 32'd0) && (wr_addr == '0));

    // Storage update.
    always_comb begin
        mem_d  = mem_q;
        flag_d = flag_q;
        if (wr_accept_c) begin
            mem_d[wr_addr]  = wr_data;
            flag_d[wr_addr] = 1'b1;
        end
    end

    // Read ports: hold when disabled; zero entry wins, then same-edge forwarding.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_init_d = rd_init_q;
        ra        = '0;
        if (rd_en) begin
            for (int unsigned i = 0; i < NRD; i++) begin
                ra = rd_addr[i*ADDR_W +: ADDR_W];
                if ((ZERO_REG != 32'd0) && (ra == '0)) begin
                    rd_data_d[i*DATA_W +: DATA_W] = '0;
                    rd_init_d[i]                  = 1'b1;
                end else if ((BYPASS != 32'd0) && wr_accept_c && (wr_addr == ra)) begin
                    rd_data_d[i*DATA_W +: DATA_W] = wr_data;
                    rd_init_d[i]                  = 1'b1;
                end else begin
                    rd_data_d[i*DATA_W +: DATA_W] = mem_q[ra];
                    rd_init_d[i]                  = flag_q[ra];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            flag_q    <= '0;
            rd_data_q <= '0;
            rd_init_q <= '0;
        end else begin
            mem_q     <= mem_d;
            flag_q    <= flag_d;
            rd_data_q <= rd_data_d;
            rd_init_q <= rd_init_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_init = rd_init_q;

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: drives two register-file configurations side by side.
//   A: defaults (32-bit, 32 entries, 2 ports, zero entry, forwarding)
//   B: 16-bit, 8 entries, 4 ports, no zero entry, no forwarding
// Expected outputs come from array models and flow through a scoreboard queue.
module tb_reg_file_param;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_wr_en, a_rd_en;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_init;

    logic        b_wr_en, b_rd_en;
    logic [2:0]  b_wr_addr;
    logic [15:0] b_wr_data;
    logic [11:0] b_rd_addr;
    logic [63:0] b_rd_data;
    logic [3:0]  b_rd_init;

    reg_file_param dut_a (
        .clk(clk), .rst(rst),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr),
        .rd_data(a_rd_data), .rd_init(a_rd_init)
    );

    reg_file_param #(
        .DATA_W(16), .ADDR_W(3), .NRD(4), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .rd_init(b_rd_init)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] ad;
        logic [1:0]  ai;
        logic [63:0] bd;
        logic [3:0]  bi;
    } exp_t;

    exp_t sb[$];

    int n_vec  = 0;
    int n_fail = 0;

    // Reference state: entry contents, written flags, last read results.
    logic [31:0] ma   [32];
    logic        ma_f [32];
    logic [15:0] mb   [8];
    logic        mb_f [8];
    logic [63:0] ea_d, eb_d;
    logic [1:0]  ea_i;
    logic [3:0]  eb_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin ma[i] = '0; ma_f[i] = 1'b0; end
        for (int i = 0; i < 8; i++)  begin mb[i] = '0; mb_f[i] = 1'b0; end
        ea_d = '0; ea_i = '0; eb_d = '0; eb_i = '0;
    endtask

    task automatic idle();
        a_wr_en = 1'b0; a_rd_en = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
    endtask

    // One clock: evaluate the models on the current inputs, queue the
    // expected outputs, advance past the edge.
    task automatic step();
        logic [4:0] ad;
        logic [2:0] bd;
        // A forwards: the write lands first, then every port reads.
        if (a_wr_en && a_wr_addr != 5'd0) begin
            ma[a_wr_addr]   = a_wr_data;
            ma_f[a_wr_addr] = 1'b1;
        end
        if (a_rd_en) begin
            for (int p = 0; p < 2; p++) begin
                ad = a_rd_addr[p*5 +: 5];
                if (ad == 5'd0) begin
                    ea_d[p*32 +: 32] = '0;
                    ea_i[p]          = 1'b1;
                end else begin
                    ea_d[p*32 +: 32] = ma[ad];
                    ea_i[p]          = ma_f[ad];
                end
            end
        end
        // B does not forward: ports read the old contents, then the write lands.
        if (b_rd_en) begin
            for (int p = 0; p < 4; p++) begin
                bd = b_rd_addr[p*3 +: 3];
                eb_d[p*16 +: 16] = mb[bd];
                eb_i[p]          = mb_f[bd];
            end
        end
        if (b_wr_en) begin
            mb[b_wr_addr]   = b_wr_data;
            mb_f[b_wr_addr] = 1'b1;
        end
        sb.push_back('{ad: ea_d, ai: ea_i, bd: eb_d, bi: eb_i});
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " a_rd_data"}, a_rd_data, 64'd0);
        check({tag, " a_rd_init"}, 64'(a_rd_init), 64'd0);
        check({tag, " b_rd_data"}, b_rd_data, 64'd0);
        check({tag, " b_rd_init"}, 64'(b_rd_init), 64'd0);
    endtask

    // Monitor: the outputs are registered every edge, so one entry per clock.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && sb.size() > 0) begin
            e = sb.pop_front();
            check("a_rd_data", a_rd_data, e.ad);
            check("a_rd_init", 64'(a_rd_init), 64'(e.ai));
            check("b_rd_data", b_rd_data, e.bd);
            check("b_rd_init", 64'(b_rd_init), 64'(e.bi));
        end
    end

    initial begin
        idle();
        a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
        b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
        model_clear();

        // Held in reset with requests active: nothing may change.
        a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'h0BAD_0BAD; a_rd_en = 1'b1;
        b_wr_en = 1'b1; b_wr_addr = 3'd4; b_wr_data = 16'h0BAD;        b_rd_en = 1'b1;
        a_rd_addr = {5'd4, 5'd4}; b_rd_addr = {4{3'd4}};
        repeat (2) begin
            @(posedge clk);
            #1;
            check_zero("in_reset");
        end
        #1;
        idle();
        rst = 1'b0;

        // Write then read back: A entry 7, B entries 2 and 5.
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'hDEAD_BEEF;
        b_wr_en = 1'b1; b_wr_addr = 3'd2; b_wr_data = 16'h1111;
        step();
        idle();
        a_rd_en = 1'b1; a_rd_addr = {5'd1, 5'd7};
        b_wr_en = 1'b1; b_wr_addr = 3'd5; b_wr_data = 16'h2222;
        step();
        idle();
        b_rd_en = 1'b1; b_rd_addr = {3'd6, 3'd2, 3'd5, 3'd2};
        step();

        // Same-edge write/read collision on entry 3.
        idle();
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h1234_5678;
        a_rd_en = 1'b1; a_rd_addr = {5'd3, 5'd3};
        b_wr_en = 1'b1; b_wr_addr = 3'd3; b_wr_data = 16'h5678;
        b_rd_en = 1'b1; b_rd_addr = {3'd0, 3'd1, 3'd3, 3'd3};
        step();
        idle();
        b_rd_en = 1'b1;
        step();

        // Write to the zero entry is dropped, even with a same-edge read.
        idle();
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFF_FFFF;
        a_rd_en = 1'b1; a_rd_addr = {5'd0, 5'd0};
        step();
        idle();
        a_rd_en = 1'b1;
        step();

        // Outputs hold while rd_en is low, even across a write to the read entry.
        idle();
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'hA5A5_A5A5;
        step();
        idle();
        a_rd_en = 1'b1; a_rd_addr = {5'd0, 5'd9};
        step();
        idle();
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h0000_0001;
        step();
        idle();
        step();
        a_rd_en = 1'b1;
        step();

        // Randomised traffic on both instances.
        for (int n = 0; n < 1500; n++) begin
            a_wr_en   = ($urandom_range(0, 99) < 60);
            a_wr_addr = 5'($urandom);
            a_wr_data = $urandom;
            a_rd_en   = ($urandom_range(0, 99) < 70);
            a_rd_addr = ($urandom_range(0, 3) == 0) ? {a_wr_addr, 5'($urandom)} : 10'($urandom);
            b_wr_en   = ($urandom_range(0, 99) < 60);
            b_wr_addr = 3'($urandom);
            b_wr_data = 16'($urandom);
            b_rd_en   = ($urandom_range(0, 99) < 70);
            b_rd_addr = 12'($urandom);
            step();
        end

        // Fill every A entry, read a couple back, then reset mid-cycle.
        idle();
        for (int e = 1; e < 32; e++) begin
            a_wr_en = 1'b1; a_wr_addr = 5'(e); a_wr_data = 32'hC000_0000 | 32'(e);
            b_wr_en = 1'b1; b_wr_addr = 3'(e); b_wr_data = 16'(e * 3 + 1);
            step();
        end
        idle();
        a_rd_en = 1'b1; a_rd_addr = {5'd31, 5'd17};
        b_rd_en = 1'b1; b_rd_addr = {3'd7, 3'd6, 3'd5, 3'd1};
        step();
        idle();

        #1;
        rst = 1'b1;
        a_wr_en = 1'b1; a_rd_en = 1'b1; b_wr_en = 1'b1; b_rd_en = 1'b1;
        #1;
        check_zero("async_reset");
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_hold");
        #1;
        idle();
        rst = 1'b0;

        // Every entry reads back as unwritten after reset.
        for (int e = 0; e < 16; e++) begin
            a_rd_en = 1'b1; a_rd_addr = {5'(2 * e + 1), 5'(2 * e)};
            b_rd_en = 1'b1; b_rd_addr = {3'(e + 3), 3'(e + 2), 3'(e + 1), 3'(e)};
            step();
        end
        idle();
        step();

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Backstop against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
